hazard_ctrl: RTL and testbench

Next-generation pipeline hazard controller for the 5-stage LC-3b core (IF/ID/EX/MEM/WB).
- Generates load/reset controls for the fd, dx, xm and mw pipeline registers, plus load_pc.
- Adds three things the previous controller lacks: operand forwarding selects, multi-cycle I/D memory stall handling with a redirect-hold FSM, and saturating performance counters.
- Register-index width and hazard policy are parameterised.

---
 rtl/hazard_ctrl_if.sv | 53 +++++
 rtl/hazard_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_hazard_ctrl.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side signal bundle of the LC-3b hazard controller: stage status in,
// pipeline register controls, forwarding selects and performance counters out.
interface hazard_ctrl_if #(
    parameter int REG_W = 3,
    parameter int CNT_W = 16
);
    logic [REG_W-1:0] id_sr1;
    logic [REG_W-1:0] id_sr2;
    logic             id_sr1_v;
    logic             id_sr2_v;
    logic [REG_W-1:0] ex_dest;
    logic [REG_W-1:0] mem_dest;
    logic             ex_dest_v;
    logic             mem_dest_v;
    logic             ex_is_load;
    logic             mem_is_load;
    logic             mem_redirect;
    logic             imem_read;
    logic             imem_resp;
    logic             dmem_req;
    logic             dmem_resp;
    logic             perf_clr;
    logic             load_fd;
    logic             reset_fd;
    logic             load_dx;
    logic             reset_dx;
    logic             load_xm;
    logic             reset_xm;
    logic             load_mw;
    logic             reset_mw;
    logic             load_pc;
    logic             redirect_hold;
    logic [1:0]       fwd_a_sel;
    logic [1:0]       fwd_b_sel;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output id_sr1, id_sr2, id_sr1_v, id_sr2_v, ex_dest, mem_dest, ex_dest_v, mem_dest_v,
               ex_is_load, mem_is_load, mem_redirect, imem_read, imem_resp, dmem_req,
               dmem_resp, perf_clr,
        input  load_fd, reset_fd, load_dx, reset_dx, load_xm, reset_xm, load_mw, reset_mw,
               load_pc, redirect_hold, fwd_a_sel, fwd_b_sel, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_sr1, id_sr2, id_sr1_v, id_sr2_v, ex_dest, mem_dest, ex_dest_v, mem_dest_v,
               ex_is_load, mem_is_load, mem_redirect, imem_read, imem_resp, dmem_req,
               dmem_resp, perf_clr,
        output load_fd, reset_fd, load_dx, reset_dx, load_xm, reset_xm, load_mw, reset_mw,
               load_pc, redirect_hold, fwd_a_sel, fwd_b_sel, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage LC-3b pipeline: stalls, flushes, operand
// forwarding, fetch-redirect hold FSM and saturating stall/flush counters.
module hazard_ctrl #(
    parameter int REG_W          = 3,
    parameter bit FORWARD_EN     = 1'b1,
    parameter bit MEM_LOAD_STALL = 1'b0,
    parameter int CNT_W          = 16
) (
    input  logic          clk,
    input  logic          rst,
    hazard_ctrl_if.slave  hz
);

    typedef enum logic [0:0] {
        ST_RUN        = 1'b0,
        ST_REDIR_WAIT = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_r;
    state_t           state_next_s;
    logic [CNT_W-1:0] stall_cnt_r;
    logic [CNT_W-1:0] flush_cnt_r;

    logic load_fd_s, reset_fd_s, load_dx_s, reset_dx_s;
    logic load_xm_s, reset_xm_s, load_mw_s, reset_mw_s;
    logic load_pc_s, redirect_hold_s, flush_inc_s, stall_inc_s;
    logic dmem_stall_s, imem_stall_s, data_hazard_s;
    logic m1_ex_s, m2_ex_s, m1_mem_s, m2_mem_s;
    logic [1:0] fwd_a_sel_s, fwd_b_sel_s;

    function automatic logic match_f(input logic [REG_W-1:0] sr, input logic sr_v,
                                     input logic [REG_W-1:0] dest, input logic dest_v);
        return sr_v & dest_v & (sr == dest);
    endfunction

    // A load still in EX cannot forward; its value only appears from MEM/WB.
    function automatic logic [1:0] fwd_sel_f(input logic m_ex, input logic ex_load,
                                             input logic m_mem);
        logic [1:0] sel;
        if (m_ex && !ex_load) begin
            sel = 2'b01;
        end else if (m_mem) begin
            sel = 2'b10;
        end else begin
            sel = 2'b00;
        end
        return sel;
    endfunction

    assign dmem_stall_s = hz.dmem_req & ~hz.dmem_resp;
    assign imem_stall_s = hz.imem_read & ~hz.imem_resp;
    assign m1_ex_s      = match_f(hz.id_sr1, hz.id_sr1_v, hz.ex_dest, hz.ex_dest_v);
    assign m2_ex_s      = match_f(hz.id_sr2, hz.id_sr2_v, hz.ex_dest, hz.ex_dest_v);
    assign m1_mem_s     = match_f(hz.id_sr1, hz.id_sr1_v, hz.mem_dest, hz.mem_dest_v);
    assign m2_mem_s     = match_f(hz.id_sr2, hz.id_sr2_v, hz.mem_dest, hz.mem_dest_v);

    // RAW hazard detection; without forwarding every EX/MEM match must stall.
    always_comb begin
        data_hazard_s = 1'b0;
        if (FORWARD_EN) begin
            data_hazard_s = (hz.ex_is_load & (m1_ex_s | m2_ex_s)) |
                            (MEM_LOAD_STALL & hz.mem_is_load & (m1_mem_s | m2_mem_s));
        end else begin
            data_hazard_s = m1_ex_s | m2_ex_s | m1_mem_s | m2_mem_s;
        end
    end

    // Next-state and pipeline register controls, highest-priority condition first.
    always_comb begin
        load_fd_s       = 1'b1;
        load_dx_s       = 1'b1;
        load_xm_s       = 1'b1;
        load_mw_s       = 1'b1;
        load_pc_s       = 1'b1;
        reset_fd_s      = 1'b0;
        reset_dx_s      = 1'b0;
        reset_xm_s      = 1'b0;
        reset_mw_s      = 1'b0;
        redirect_hold_s = 1'b0;
        flush_inc_s     = 1'b0;
        state_next_s    = state_r;
        if (rst) begin
            load_fd_s    = 1'b0;
            load_dx_s    = 1'b0;
            load_xm_s    = 1'b0;
            load_mw_s    = 1'b0;
            load_pc_s    = 1'b0;
            reset_fd_s   = 1'b1;
            reset_dx_s   = 1'b1;
            reset_xm_s   = 1'b1;
            reset_mw_s   = 1'b1;
            state_next_s = ST_RUN;
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (dmem_stall_s) begin
                        // Redirect is deliberately dropped; MEM re-presents it once it advances.
                        load_fd_s = 1'b0;
                        load_dx_s = 1'b0;
                        load_xm_s = 1'b0;
                        load_mw_s = 1'b0;
                        load_pc_s = 1'b0;
                    end else if (hz.mem_redirect) begin
                        reset_fd_s  = 1'b1;
                        reset_dx_s  = 1'b1;
                        reset_xm_s  = 1'b1;
                        flush_inc_s = 1'b1;
                        if (imem_stall_s) begin
                            load_pc_s       = 1'b0;
                            redirect_hold_s = 1'b1;
                            state_next_s    = ST_REDIR_WAIT;
                        end else begin
                            load_pc_s = 1'b1;
                        end
                    end else if (data_hazard_s || imem_stall_s) begin
                        load_fd_s  = 1'b0;
                        load_pc_s  = 1'b0;
                        load_dx_s  = 1'b0;
                        reset_dx_s = 1'b1;
                    end else begin
                        state_next_s = ST_RUN;
                    end
                end
                ST_REDIR_WAIT: begin
                    // The fetch in flight targets the old path; its word is discarded.
                    redirect_hold_s = 1'b1;
                    load_fd_s       = 1'b0;
                    reset_fd_s      = 1'b1;
                    if (hz.imem_resp) begin
                        load_pc_s    = 1'b1;
                        state_next_s = ST_RUN;
                    end else begin
                        load_pc_s = 1'b0;
                    end
                    if (dmem_stall_s) begin
                        load_dx_s = 1'b0;
                        load_xm_s = 1'b0;
                        load_mw_s = 1'b0;
                    end else begin
                        load_dx_s = 1'b1;
                    end
                end
                default: begin
                    state_next_s = ST_RUN;
                end
            endcase
        end
    end

    // Forwarding selects; EX/MEM takes priority over MEM/WB.
    always_comb begin
        fwd_a_sel_s = 2'b00;
        fwd_b_sel_s = 2'b00;
        if (FORWARD_EN && !rst) begin
            fwd_a_sel_s = fwd_sel_f(m1_ex_s, hz.ex_is_load, m1_mem_s);
            fwd_b_sel_s = fwd_sel_f(m2_ex_s, hz.ex_is_load, m2_mem_s);
        end else begin
            fwd_a_sel_s = 2'b00;
            fwd_b_sel_s = 2'b00;
        end
    end

    assign stall_inc_s = ~load_pc_s & ~rst;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Saturating performance counters; a clear beats a same-cycle increment.
    always_ff @(posedge clk) begin
        if (rst || hz.perf_clr) begin
            stall_cnt_r <= '0;
            flush_cnt_r <= '0;
        end else begin
            if (stall_inc_s && !(&stall_cnt_r)) begin
                stall_cnt_r <= stall_cnt_r + CNT_ONE;
            end
            if (flush_inc_s && !(&flush_cnt_r)) begin
                flush_cnt_r <= flush_cnt_r + CNT_ONE;
            end
        end
    end

    assign hz.load_fd       = load_fd_s;
    assign hz.reset_fd      = reset_fd_s;
    assign hz.load_dx       = load_dx_s;
    assign hz.reset_dx      = reset_dx_s;
    assign hz.load_xm       = load_xm_s;
    assign hz.reset_xm      = reset_xm_s;
    assign hz.load_mw       = load_mw_s;
    assign hz.reset_mw      = reset_mw_s;
    assign hz.load_pc       = load_pc_s;
    assign hz.redirect_hold = redirect_hold_s;
    assign hz.fwd_a_sel     = fwd_a_sel_s;
    assign hz.fwd_b_sel     = fwd_b_sel_s;
    assign hz.stall_cnt     = stall_cnt_r;
    assign hz.flush_cnt     = flush_cnt_r;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: a forwarding instance (16-bit counters) and a
// non-forwarding instance (2-bit counters) share one stimulus stream.
module tb_hazard_ctrl;

    typedef struct packed {
        logic [2:0] sr1;
        logic       sr1_v;
        logic [2:0] sr2;
        logic       sr2_v;
        logic [2:0] ex_dest;
        logic       ex_v;
        logic       ex_ld;
        logic [2:0] mem_dest;
        logic       mem_v;
        logic       mem_ld;
        logic       redir;
        logic       imem_rd;
        logic       imem_resp;
        logic       dreq;
        logic       dresp;
    } in_t;

    typedef struct {
        in_t        in;
        logic [8:0] ctl;
        logic       hold;
        logic [1:0] fa;
        logic [1:0] fb;
    } vec_t;

    // ctl = {load_fd, reset_fd, load_dx, reset_dx, load_xm, reset_xm, load_mw, reset_mw, load_pc}
    localparam logic [8:0] C_NORM  = 9'b101010101;
    localparam logic [8:0] C_STALL = 9'b000110100;
    localparam logic [8:0] C_DFRZ  = 9'b000000000;
    localparam logic [8:0] C_FLUSH = 9'b111111101;
    localparam logic [8:0] C_FLWT  = 9'b111111100;
    localparam logic [8:0] C_RW    = 9'b011010100;
    localparam logic [8:0] C_RWR   = 9'b011010101;
    localparam logic [8:0] C_RST   = 9'b010101010;

    logic clk;
    logic rst;
    logic clr;
    in_t  cur;
    int   n_tests;
    int   n_fail;
    int   exp_stall;
    int   exp_flush;
    vec_t tbl [15];

    hazard_ctrl_if #(.REG_W(3), .CNT_W(16)) ifa ();
    hazard_ctrl_if #(.REG_W(3), .CNT_W(2))  ifb ();

    hazard_ctrl #(.REG_W(3), .FORWARD_EN(1'b1), .MEM_LOAD_STALL(1'b0), .CNT_W(16)) u_fwd (
        .clk(clk), .rst(rst), .hz(ifa)
    );
    hazard_ctrl #(.REG_W(3), .FORWARD_EN(1'b0), .MEM_LOAD_STALL(1'b0), .CNT_W(2)) u_nofwd (
        .clk(clk), .rst(rst), .hz(ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign ifa.id_sr1 = cur.sr1;        assign ifb.id_sr1 = cur.sr1;
    assign ifa.id_sr1_v = cur.sr1_v;    assign ifb.id_sr1_v = cur.sr1_v;
    assign ifa.id_sr2 = cur.sr2;        assign ifb.id_sr2 = cur.sr2;
    assign ifa.id_sr2_v = cur.sr2_v;    assign ifb.id_sr2_v = cur.sr2_v;
    assign ifa.ex_dest = cur.ex_dest;   assign ifb.ex_dest = cur.ex_dest;
    assign ifa.ex_dest_v = cur.ex_v;    assign ifb.ex_dest_v = cur.ex_v;
    assign ifa.ex_is_load = cur.ex_ld;  assign ifb.ex_is_load = cur.ex_ld;
    assign ifa.mem_dest = cur.mem_dest; assign ifb.mem_dest = cur.mem_dest;
    assign ifa.mem_dest_v = cur.mem_v;  assign ifb.mem_dest_v = cur.mem_v;
    assign ifa.mem_is_load = cur.mem_ld; assign ifb.mem_is_load = cur.mem_ld;
    assign ifa.mem_redirect = cur.redir; assign ifb.mem_redirect = cur.redir;
    assign ifa.imem_read = cur.imem_rd; assign ifb.imem_read = cur.imem_rd;
    assign ifa.imem_resp = cur.imem_resp; assign ifb.imem_resp = cur.imem_resp;
    assign ifa.dmem_req = cur.dreq;     assign ifb.dmem_req = cur.dreq;
    assign ifa.dmem_resp = cur.dresp;   assign ifb.dmem_resp = cur.dresp;
    assign ifa.perf_clr = clr;          assign ifb.perf_clr = clr;

    // While waiting for the fetch (hold set, dx not being flushed) no new redirect may arrive.
    assert property (@(posedge clk) disable iff (rst)
        !(ifa.redirect_hold && !ifa.reset_dx && ifa.mem_redirect))
        else $error("second redirect seen while waiting for fetch");

    function automatic in_t mk(input logic [2:0] sr1, input logic s1v, input logic [2:0] sr2,
                               input logic s2v, input logic [2:0] exd, input logic exv,
                               input logic exl, input logic [2:0] memd, input logic memv,
                               input logic meml, input logic redir, input logic ird,
                               input logic iresp, input logic dreq, input logic dresp);
        return '{sr1, s1v, sr2, s2v, exd, exv, exl, memd, memv, meml, redir, ird, iresp, dreq, dresp};
    endfunction

    function automatic logic [13:0] out_a();
        return {ifa.load_fd, ifa.reset_fd, ifa.load_dx, ifa.reset_dx, ifa.load_xm, ifa.reset_xm,
                ifa.load_mw, ifa.reset_mw, ifa.load_pc, ifa.redirect_hold, ifa.fwd_a_sel, ifa.fwd_b_sel};
    endfunction

    function automatic logic [13:0] out_b();
        return {ifb.load_fd, ifb.reset_fd, ifb.load_dx, ifb.reset_dx, ifb.load_xm, ifb.reset_xm,
                ifb.load_mw, ifb.reset_mw, ifb.load_pc, ifb.redirect_hold, ifb.fwd_a_sel, ifb.fwd_b_sel};
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Check forwarding-instance outputs at the negedge, update the counter model, then advance.
    task automatic step_a(input string name, input in_t v, input logic [8:0] ctl,
                          input logic hold, input logic [1:0] fa, input logic [1:0] fb);
        cur = v;
        @(negedge clk);
        chk(name, {18'd0, out_a()}, {18'd0, ctl, hold, fa, fb});
        if (!ctl[0]) exp_stall++;
        if (ctl[3]) exp_flush++;
        next_cycle();
    endtask

    task automatic chk_cnt(input string name);
        chk({name, "_stall"}, {16'd0, ifa.stall_cnt}, exp_stall);
        chk({name, "_flush"}, {16'd0, ifa.flush_cnt}, exp_flush);
    endtask

    in_t idle, ldr_hz, alu_hz;

    initial begin
        n_tests = 0; n_fail = 0; exp_stall = 0; exp_flush = 0;
        clr = 1'b0;
        idle   = mk(3'd0,1'b0,3'd0,1'b0, 3'd0,1'b0,1'b0, 3'd0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0);
        ldr_hz = mk(3'd2,1'b1,3'd0,1'b0, 3'd2,1'b1,1'b1, 3'd0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0);
        alu_hz = mk(3'd3,1'b1,3'd3,1'b1, 3'd3,1'b1,1'b0, 3'd3,1'b1,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0);

        tbl[0]  = '{idle, C_NORM, 1'b0, 2'b00, 2'b00};
        tbl[1]  = '{alu_hz, C_NORM, 1'b0, 2'b01, 2'b01};
        tbl[2]  = '{mk(3'd1,1'b1,3'd5,1'b1, 3'd0,1'b0,1'b0, 3'd5,1'b1,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0), C_NORM, 1'b0, 2'b00, 2'b10};
        tbl[3]  = '{ldr_hz, C_STALL, 1'b0, 2'b00, 2'b00};
        tbl[4]  = '{mk(3'd2,1'b1,3'd0,1'b0, 3'd0,1'b0,1'b0, 3'd2,1'b1,1'b1, 1'b0,1'b0,1'b0,1'b0,1'b0), C_NORM, 1'b0, 2'b10, 2'b00};
        tbl[5]  = '{mk(3'd4,1'b0,3'd0,1'b0, 3'd4,1'b1,1'b0, 3'd0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0), C_NORM, 1'b0, 2'b00, 2'b00};
        tbl[6]  = '{mk(3'd6,1'b1,3'd0,1'b0, 3'd6,1'b0,1'b0, 3'd6,1'b1,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0), C_NORM, 1'b0, 2'b10, 2'b00};
        tbl[7]  = '{mk(3'd0,1'b0,3'd0,1'b0, 3'd0,1'b0,1'b0, 3'd0,1'b0,1'b0, 1'b0,1'b1,1'b0,1'b0,1'b0), C_STALL, 1'b0, 2'b00, 2'b00};
        tbl[8]  = '{mk(3'd0,1'b0,3'd0,1'b0, 3'd0,1'b0,1'b0, 3'd0,1'b0,1'b0, 1'b0,1'b1,1'b1,1'b0,1'b0), C_NORM, 1'b0, 2'b00, 2'b00};
        tbl[9]  = '{mk(3'd2,1'b1,3'd0,1'b0, 3'd2,1'b1,1'b1, 3'd0,1'b0,1'b0, 1'b0,1'b1,1'b0,1'b1,1'b0), C_DFRZ, 1'b0, 2'b00, 2'b00};
        tbl[10] = '{mk(3'd0,1'b0,3'd0,1'b0, 3'd0,1'b0,1'b0, 3'd0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b1,1'b1), C_NORM, 1'b0, 2'b00, 2'b00};
        tbl[11] = '{mk(3'd0,1'b0,3'd0,1'b0, 3'd0,1'b0,1'b0, 3'd0,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b0,1'b0), C_FLUSH, 1'b0, 2'b00, 2'b00};
        tbl[12] = '{mk(3'd0,1'b0,3'd0,1'b0, 3'd0,1'b0,1'b0, 3'd0,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b1,1'b0), C_DFRZ, 1'b0, 2'b00, 2'b00};
        tbl[13] = '{mk(3'd2,1'b1,3'd0,1'b0, 3'd2,1'b1,1'b1, 3'd0,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b0,1'b0), C_FLUSH, 1'b0, 2'b00, 2'b00};
        tbl[14] = '{mk(3'd0,1'b0,3'd7,1'b1, 3'd7,1'b1,1'b0, 3'd7,1'b1,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0), C_NORM, 1'b0, 2'b00, 2'b01};

        // Reset with a forwarding match present: forwarding must stay off.
        rst = 1'b1;
        cur = alu_hz;
        next_cycle();
        @(negedge clk);
        chk("reset_outputs", {18'd0, out_a()}, {18'd0, C_RST, 1'b0, 2'b00, 2'b00});
        next_cycle();
        rst = 1'b0;
        cur = idle;
        chk_cnt("reset_cnt");

        // Load-use: one stall cycle, then MEM/WB forwarding of the loaded value.
        step_a("ldr_stall", ldr_hz, C_STALL, 1'b0, 2'b00, 2'b00);
        chk("ldr_stall_cnt", {16'd0, ifa.stall_cnt}, 32'd1);
        step_a("ldr_fwd", tbl[4].in, C_NORM, 1'b0, 2'b10, 2'b00);

        for (int i = 0; i < 15; i++) begin
            step_a($sformatf("vec%0d", i), tbl[i].in, tbl[i].ctl, tbl[i].hold, tbl[i].fa, tbl[i].fb);
        end
        cur = idle;
        chk_cnt("table_cnt");

        // Data-memory stall for 3 cycles with a redirect pending throughout.
        cur = idle; cur.dreq = 1'b1; cur.redir = 1'b1;
        step_a("dstall_c1", cur, C_DFRZ, 1'b0, 2'b00, 2'b00);
        step_a("dstall_c2", cur, C_DFRZ, 1'b0, 2'b00, 2'b00);
        cur.dresp = 1'b1;
        step_a("dstall_c3", cur, C_FLUSH, 1'b0, 2'b00, 2'b00);
        cur = idle;
        chk_cnt("dstall_cnt");

        // Redirect while a fetch is outstanding: hold the target until the fetch returns.
        cur = idle; cur.redir = 1'b1; cur.imem_rd = 1'b1;
        step_a("redir_c1", cur, C_FLWT, 1'b1, 2'b00, 2'b00);
        cur.redir = 1'b0;
        step_a("redir_wait", cur, C_RW, 1'b1, 2'b00, 2'b00);
        cur.imem_resp = 1'b1;
        step_a("redir_resp", cur, C_RWR, 1'b1, 2'b00, 2'b00);
        step_a("redir_run", idle, C_NORM, 1'b0, 2'b00, 2'b00);
        cur = idle;
        chk_cnt("redir_cnt");

        // Reset while in REDIR_WAIT returns to RUN with counters cleared.
        cur = idle; cur.redir = 1'b1; cur.imem_rd = 1'b1;
        step_a("rstw_enter", cur, C_FLWT, 1'b1, 2'b00, 2'b00);
        cur.redir = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("rstw_reset", {18'd0, out_a()}, {18'd0, C_RST, 1'b0, 2'b00, 2'b00});
        next_cycle();
        rst = 1'b0;
        exp_stall = 0; exp_flush = 0;
        chk_cnt("rstw_cnt");
        step_a("rstw_run", idle, C_NORM, 1'b0, 2'b00, 2'b00);

        // No forwarding: ALU RAW stalls every cycle; 2-bit stall counter saturates at 3.
        chk("nofwd_cnt0", {30'd0, ifb.stall_cnt}, 32'd0);
        cur = alu_hz;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            chk($sformatf("nofwd_stall%0d", k), {18'd0, out_b()}, {18'd0, C_STALL, 1'b0, 2'b00, 2'b00});
            if (k == 1) chk("fwd_alu", {18'd0, out_a()}, {18'd0, C_NORM, 1'b0, 2'b01, 2'b01});
            next_cycle();
            chk($sformatf("nofwd_cnt%0d", k), {30'd0, ifb.stall_cnt}, (k > 3) ? 32'd3 : k);
        end
        clr = 1'b1;
        next_cycle();
        chk("nofwd_clr_win", {30'd0, ifb.stall_cnt}, 32'd0);
        clr = 1'b0;
        cur = idle;
        @(negedge clk);
        chk("nofwd_clear", {18'd0, out_b()}, {18'd0, C_NORM, 1'b0, 2'b00, 2'b00});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
